// File: rtl/hex_scroll_display_if.sv
// hex_scroll_display_if: control, write and display signals of the hex scroller
interface hex_scroll_display_if #(
  parameter int DIGITS = 6,
  parameter int MSG_LEN = 8
);
  localparam int AW = $clog2(MSG_LEN);
  logic clear;
  logic wr_en;
  logic [3:0] wr_data;
  logic run;
  logic dir;
  logic [7*DIGITS-1:0] hex;
  logic [AW-1:0] offset;
  logic [AW:0] count;
  logic full;
  modport master (output clear, wr_en, wr_data, run, dir, input hex, offset, count, full);
  modport slave (input clear, wr_en, wr_data, run, dir, output hex, offset, count, full);
endinterface

// File: rtl/hex_scroll_display.sv
// hex_scroll_display: rotates a buffered nibble message across DIGITS seven-segment displays
module hex_scroll_display #(
  parameter int DIGITS = 6,
  parameter int MSG_LEN = 8,
  parameter int DIV = 25000000
) (
  input logic CLOCK_50,
  input logic resetn,
  hex_scroll_display_if.slave bus
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = $clog2(DIV);
  localparam logic [15:0][6:0] GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  logic [3:0] buf_q [MSG_LEN];
  logic [3:0] buf_d [MSG_LEN];
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [DW-1:0] div_q, div_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic full, tick, wr;
  assign full = count_q == (AW+1)'(MSG_LEN);
  assign tick = bus.run && div_q == DW'(DIV - 1);
  assign wr = bus.wr_en && !full;
  always_comb begin
    buf_d = buf_q;
    if (wr) buf_d[count_q[AW-1:0]] = bus.wr_data;
    count_d = bus.clear ? '0 : count_q + (AW+1)'(wr);
    offset_d = bus.clear ? '0 : !tick ? offset_q : bus.dir ? offset_q - 1'b1 : offset_q + 1'b1;
    div_d = (bus.clear || !bus.run || tick) ? '0 : div_q + 1'b1;
  end
  // Digit index wraps naturally because MSG_LEN is a power of two.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [AW-1:0] j;
    assign j = offset_q + AW'(g);
    assign hex_d[7*g +: 7] = ({1'b0, j} < count_q) ? GLYPH[buf_q[j]] : 7'h7F;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      buf_q <= '{default: '0};
      count_q <= '0;
      offset_q <= '0;
      div_q <= '0;
      hex_q <= '1;
    end else begin
      buf_q <= buf_d;
      count_q <= count_d;
      offset_q <= offset_d;
      div_q <= div_d;
      hex_q <= hex_d;
    end
  end
  assign bus.hex = hex_q;
  assign bus.offset = offset_q;
  assign bus.count = count_q;
  assign bus.full = full;
endmodule

// File: tb/tb_hex_scroll_display.sv
// tb_hex_scroll_display: table-driven scoreboard bench for the hex scroller
module tb_hex_scroll_display;
  localparam int DIGITS = 6;
  localparam int MSG_LEN = 8;
  localparam int DIV = 4;
  localparam logic [6:0] B = 7'h7F;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  hex_scroll_display_if #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN)) bus ();
  hex_scroll_display #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .DIV(DIV)) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic clear, wr_en, run, dir;
    logic [3:0] wr_data;
    logic [3:0] e_count;
    logic [2:0] e_off;
    logic e_full;
    logic chk_hex;
    logic [41:0] e_hex;
  } vec_t;
  typedef struct {
    string name;
    logic [3:0] e_count;
    logic [2:0] e_off;
    logic e_full;
    logic chk_hex;
    logic [41:0] e_hex;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  int passed = 0;
  int total = 0;
  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction
  function automatic vec_t mk(input logic c, input logic w, input int d, input logic r, input logic dr,
                              input int ec, input int eo, input logic ef,
                              input logic ch = 1'b0, input logic [41:0] eh = '0);
    vec_t v;
    v.clear = c;
    v.wr_en = w;
    v.wr_data = 4'(d);
    v.run = r;
    v.dir = dr;
    v.e_count = 4'(ec);
    v.e_off = 3'(eo);
    v.e_full = ef;
    v.chk_hex = ch;
    v.e_hex = eh;
    return v;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    bus.clear = v.clear;
    bus.wr_en = v.wr_en;
    bus.wr_data = v.wr_data;
    bus.run = v.run;
    bus.dir = v.dir;
    sb.push_back('{name, v.e_count, v.e_off, v.e_full, v.chk_hex, v.e_hex});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".count"}, 64'(bus.count), 64'(e.e_count));
    check({e.name, ".offset"}, 64'(bus.offset), 64'(e.e_off));
    check({e.name, ".full"}, 64'(bus.full), 64'(e.e_full));
    if (e.chk_hex) check({e.name, ".hex"}, 64'(bus.hex), 64'(e.e_hex));
  endtask
  task automatic check_reset(input string name);
    check({name, ".hex"}, 64'(bus.hex), 64'(42'h3FFFFFFFFFF));
    check({name, ".offset"}, 64'(bus.offset), 64'd0);
    check({name, ".count"}, 64'(bus.count), 64'd0);
    check({name, ".full"}, 64'(bus.full), 64'd0);
  endtask
  initial begin
    // write 1,2,3 then fill to 8, overflow with F, clear racing a write
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, {B, B, B, glyph(3), glyph(2), glyph(1)}));
    for (int k = 4; k <= 8; k++) tbl.push_back(mk(0, 1, k, 0, 0, k, 0, k == 8));
    tbl.push_back(mk(0, 1, 15, 0, 0, 8, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8, 0, 1, 1, {glyph(6), glyph(5), glyph(4), glyph(3), glyph(2), glyph(1)}));
    tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, {6{B}}));
    // load 0..7 and scroll forward through a full wrap, then backwards
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 1, k, 0, 0, k + 1, 0, k == 7));
    for (int k = 1; k <= 32; k++)
      tbl.push_back(mk(0, 0, 0, 1, 0, 8, (k / 4) % 8, 1, k == 5 || k == 29,
        k == 5 ? {glyph(6), glyph(5), glyph(4), glyph(3), glyph(2), glyph(1)}
               : {glyph(4), glyph(3), glyph(2), glyph(1), glyph(0), glyph(7)}));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 8, k == 4 ? 7 : 0, 1));
    // write on the tick edge, then clear on a tick edge
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 1, 9 + k, 1, 0, k, k == 4 ? 1 : 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0, 1, {B, B, B, glyph(13), glyph(12), glyph(11)}));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, {6{B}}));

    bus.clear = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 4'h7;
    bus.run = 1'b1;
    bus.dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");
    resetn = 1'b1;
    apply(mk(0, 1, 5, 0, 0, 1, 0, 0), "first_write");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, {B, B, B, B, B, glyph(5)}), "first_write_hex");
    apply(mk(0, 1, 6, 1, 0, 2, 0, 0), "pre_async");
    apply(mk(0, 0, 0, 1, 0, 2, 0, 0), "pre_async2");
    #3;
    resetn = 1'b0;
    #1;
    check_reset("async_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // pause mid-period must discard the partial divider count
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0), "pause_idle");
    repeat (2) apply(mk(0, 0, 0, 1, 0, 0, 0, 0), "pause_run");
    repeat (10) apply(mk(0, 0, 0, 0, 0, 0, 0, 0), "paused");
    for (int k = 1; k <= 4; k++) apply(mk(0, 0, 0, 1, 0, 0, k == 4 ? 1 : 0, 0), $sformatf("resume%0d", k));
    // dir only matters on the tick edge
    for (int k = 1; k <= 4; k++) apply(mk(0, 0, 0, 1, k != 4, 0, k == 4 ? 2 : 1, 0), $sformatf("dir_tick%0d", k));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
